// File: rtl/serial_tx8.sv
// serial_tx8: 8-bit parallel-to-serial transmitter with start/stop framing
// (8N1) and an optional even-parity bit. The line idles high and every bit
// is held for CLKS_PER_BIT clocks.
//
// Handshake: load is sampled on a rising clock edge only while ready=1.
// ready is high in IDLE and during the last cycle of the stop bit, the same
// cycle that done pulses. A load seen in that final stop cycle starts the
// next frame with no idle gap. A load seen while busy=1 is dropped.
module serial_tx8 #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:7] d,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       txd,
    output logic       done,
    output logic [2:0] state_dbg
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic          bit_end;
    logic          accept;

    // Bit boundary and frame-end decode; all sourced from registers.
    always_comb begin
        bit_end = (clk_cnt_q == CNT_LAST);
        done    = (state_q == S_STOP) && bit_end;
        ready   = (state_q == S_IDLE) || done;
        busy    = ~ready;
        accept  = ready && load;
    end

    // Next-state logic: txd_d is the line value for the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        txd_d     = txd_q;

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                    txd_d     = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        if (PARITY_EN) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // d[7] is the LSB, so shift_d[0] holds the first bit on the line.
        if (accept) begin
            state_d   = S_START;
            clk_cnt_d = '0;
            bit_cnt_d = 3'd0;
            shift_d   = d;
            par_d     = ^d;
            txd_d     = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
        end
    end

    assign txd       = txd_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_tx8.sv
// tb_serial_tx8: three transmitter instances (CLKS_PER_BIT=4 no parity,
// CLKS_PER_BIT=4 even parity, CLKS_PER_BIT=1 no parity) checked cycle by
// cycle against a frame model built from the byte with plain arithmetic.
module tb_serial_tx8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] d_i     [3];
    logic       load_i  [3];
    logic       ready_w [3];
    logic       busy_w  [3];
    logic       txd_w   [3];
    logic       done_w  [3];
    logic [2:0] state_w [3];

    serial_tx8 #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_tx_a (
        .clk(clk), .rst(rst), .d(d_i[0]), .load(load_i[0]),
        .ready(ready_w[0]), .busy(busy_w[0]), .txd(txd_w[0]),
        .done(done_w[0]), .state_dbg(state_w[0])
    );
    serial_tx8 #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_tx_b (
        .clk(clk), .rst(rst), .d(d_i[1]), .load(load_i[1]),
        .ready(ready_w[1]), .busy(busy_w[1]), .txd(txd_w[1]),
        .done(done_w[1]), .state_dbg(state_w[1])
    );
    serial_tx8 #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_tx_c (
        .clk(clk), .rst(rst), .d(d_i[2]), .load(load_i[2]),
        .ready(ready_w[2]), .busy(busy_w[2]), .txd(txd_w[2]),
        .done(done_w[2]), .state_dbg(state_w[2])
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1;
    // each bit repeated cpb times.
    task automatic push_frame(input logic [7:0] b, input int cpb, input bit par);
        logic [0:0] bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(1'((b >> i) & 8'd1));
        if (par) bits.push_back(1'($countones(b) % 2));
        bits.push_back(1'b1);
        foreach (bits[i]) for (int c = 0; c < cpb; c++) exp_q.push_back(bits[i]);
    endtask

    task automatic check_idle(input int id, input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "_txd"},   txd_w[id],   1);
            check({tag, "_ready"}, ready_w[id], 1);
            check({tag, "_busy"},  busy_w[id],  0);
            check({tag, "_done"},  done_w[id],  0);
        end
    endtask

    // ---------------- driver ----------------
    // Sends b0 (and b1 back-to-back when b2b=1). At frame cycle chg_k, d is
    // changed to chg_v; at pulse_k, load is raised for one cycle while busy.
    task automatic run_seq(input int id, input int cpb, input bit par,
                           input logic [7:0] b0, input logic [7:0] b1, input bit b2b,
                           input int chg_k, input logic [7:0] chg_v, input int pulse_k);
        int flen;
        int total;
        bit last;
        logic [0:0] e;
        exp_q.delete();
        push_frame(b0, cpb, par);
        if (b2b) push_frame(b1, cpb, par);
        flen  = (par ? 11 : 10) * cpb;
        total = exp_q.size();
        @(negedge clk);
        check("pre_ready", ready_w[id], 1);
        d_i[id]    = b0;
        load_i[id] = 1'b1;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            e    = exp_q.pop_front();
            last = ((k + 1) % flen) == 0;
            check("txd",   txd_w[id],   e);
            check("done",  done_w[id],  last);
            check("ready", ready_w[id], last);
            check("busy",  busy_w[id],  !last);
            load_i[id] = b2b && (k < total - 1);
            if (k == chg_k)   d_i[id] = chg_v;
            if (k == pulse_k) load_i[id] = 1'b1;
            if (b2b && k == flen - 1) d_i[id] = b1;
        end
        load_i[id] = 1'b0;
        check_idle(id, 4, "post");
    endtask

    task automatic reset_mid_frame(input logic [7:0] b);
        @(negedge clk);
        d_i[0]    = b;
        load_i[0] = 1'b1;
        // Frame cycle 17 on CLKS_PER_BIT=4 is inside data bit 3.
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            load_i[0] = 1'b0;
        end
        check("mid_busy", busy_w[0], 1);
        #1 rst = 1'b0;
        #1;
        check("arst_txd",   txd_w[0],   1);
        check("arst_ready", ready_w[0], 1);
        check("arst_busy",  busy_w[0],  0);
        check("arst_done",  done_w[0],  0);
        check("arst_state", state_w[0], 0);
        @(negedge clk);
        rst = 1'b1;
        check_idle(0, 20, "after_rst");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            d_i[i]    = 8'h00;
            load_i[i] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_txd",   txd_w[i],   1);
            check("rst_ready", ready_w[i], 1);
            check("rst_busy",  busy_w[i],  0);
            check("rst_done",  done_w[i],  0);
            check("rst_state", state_w[i], 0);
        end
        rst = 1'b1;
        check_idle(0, 2, "idle");

        // Directed cases
        run_seq(0, 4, 1'b0, 8'h6D, 8'h00, 1'b0, -1, 8'h00, -1);
        run_seq(1, 4, 1'b1, 8'h6D, 8'h00, 1'b0, -1, 8'h00, -1);
        run_seq(1, 4, 1'b1, 8'hC5, 8'h00, 1'b0, -1, 8'h00, -1);
        run_seq(0, 4, 1'b0, 8'hAA, 8'h00, 1'b0, 12, 8'h25, 12);
        run_seq(2, 1, 1'b0, 8'h00, 8'hFF, 1'b1, -1, 8'h00, -1);
        run_seq(0, 4, 1'b0, 8'h52, 8'h00, 1'b0, 0, 8'hBA, -1);
        run_seq(2, 1, 1'b0, 8'h81, 8'h00, 1'b0, -1, 8'h00, -1);
        reset_mid_frame(8'h3C);

        // Randomized frames on every instance
        for (int n = 0; n < 8; n++) begin
            for (int id = 0; id < 3; id++) begin
                int cpb;
                bit par;
                int flen;
                cpb  = (id == 2) ? 1 : 4;
                par  = (id == 1);
                flen = (par ? 11 : 10) * cpb;
                run_seq(id, cpb, par, 8'($urandom), 8'($urandom), 1'($urandom),
                        $urandom_range(0, flen - 2), 8'($urandom),
                        (flen > 3) ? $urandom_range(1, flen - 2) : -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_tx8.md
Name: serial_tx8

Overview:
- Byte transmitter: accepts an 8-bit parallel word and shifts it out on a single line with start/stop framing (8N1, optional parity).
- Sits downstream of the 8-bit latch/register stage and carries latched data off-block serially.
- A matching deserializer on the far side restores the parallel byte.

Parameters:
- CLKS_PER_BIT, 4, clk cycles each serial bit is held; legal range 1..255.
- PARITY_EN, 0, 1 = insert an even-parity bit between the last data bit and the stop bit.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- d    in  [0:7]  byte to send; bit 0 is the MSB, bit 7 the LSB.
- load in  1  request to send d; accepted only when ready=1.
- ready out 1  1 = idle, able to accept load.
- busy out 1  1 = frame in progress; always the inverse of ready.
- txd  out 1  serial line, idle high.
- done out 1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (rst=0, asynchronous) forces: state IDLE, txd=1, ready=1, busy=0, done=0, bit and clock counters 0, shift register 0.
  - Holds while rst=0. Reset during a frame aborts it immediately; no partial stop bit is sent.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1, ready=1.
  - On a rising edge with load=1, d is copied into the shift register and the FSM moves to START.
  - txd=0 is visible after that same edge, so latency from accept to start bit is 1 cycle.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, LSB first (d[7] first, d[0] last).
  - Each bit is held for CLKS_PER_BIT cycles; the 3-bit bit counter goes 0..7.
  - After bit 7: go to PARITY if PARITY_EN=1, else STOP.
- PARITY: txd = XOR of the 8 captured bits (even parity), held CLKS_PER_BIT cycles, then STOP.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
  - On the last stop cycle's edge: done=1 for exactly one cycle, the FSM returns to IDLE, and ready=1 in that same cycle.
- Clock counter:
  - Reloads to 0 at every bit boundary.
  - Width is ceil(log2(CLKS_PER_BIT)), with a minimum of 1 bit.
  - CLKS_PER_BIT=1 must work: one cycle per bit.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- Input handling:
  - load while busy is ignored and not queued.
  - Changes to d after acceptance have no effect on the frame in flight.
- Back-to-back: load=1 in the cycle done=1 (ready=1) is accepted. The next start bit follows the previous stop bit with no idle gap.
- load held high continuously produces continuous frames, each sampling d at its own accept edge.
- No combinational path from load or d to txd; txd is registered.

Test Plan:
- Reset: rst=0 mid-frame (during DATA bit 3) -> txd=1, ready=1, busy=0, done=0 immediately without a clock edge. Release rst=1 -> line stays idle 20 cycles.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0, d=8'h6D, load one cycle:
  - txd sequence per 4-cycle slot = 0,1,0,1,1,0,1,1,0,1.
  - busy high 40 cycles; done pulses once at cycle 40; ready high again that cycle.
- Parity, PARITY_EN=1, d=8'h6D (five ones):
  - parity slot = 1, frame 44 cycles.
  - Repeat with d=8'hC5 (four ones) -> parity slot = 0.
- Load while busy: accept 8'hAA, pulse load with d=8'h25 at cycle 12 -> frame carries 8'hAA only; one done pulse; no second frame.
- Back-to-back, CLKS_PER_BIT=1: load held high with d=8'h00 then 8'hFF, switched at the first done -> txd = 0,00000000,1,0,11111111,1 with no idle gap.
- Data stability: change d from 8'h52 to 8'hBA one cycle after accept -> serialized bits match 8'h52 (LSB first 0,1,0,0,1,0,1,0).
